// File: rtl/tdm_fir_pkg.sv
// Shared types for the TDM FIR channel scheduler: slot index, sequencer state and the
// {real, slot} tag that travels alongside each sample through the FIR.
package tdm_fir_pkg;

  // Slot width is fixed here, so the scheduler's NUM_CHANNELS must match this value.
  localparam int DEF_NUM_CHANNELS = 4;
  localparam int SLOT_W           = $clog2(DEF_NUM_CHANNELS);

  typedef logic [SLOT_W-1:0] slot_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } sched_state_e;

  typedef struct packed {
    logic  is_real;
    slot_t slot;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/tdm_tag_pipe.sv
// Fixed-depth shift register that delays the per-slot tag so it lines up with the FIR
// result produced DEPTH cycles after the sample entered the delay line.
module tdm_tag_pipe
  import tdm_fir_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [TAG_W-1:0] tag_in,
  output logic [TAG_W-1:0] tag_out
);

  logic [DEPTH-1:0][TAG_W-1:0] stage_q;
  logic [DEPTH-1:0][TAG_W-1:0] stage_d;

  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/tdm_channel_scheduler.sv
// Time-multiplexes NUM_CHANNELS sample streams into a shared FIR (one slot per clk) and
// demuxes the tagged results. Optional per-channel mask under `TDM_SCHED_CHMASK_EN.
module tdm_channel_scheduler
  import tdm_fir_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int DATA_WIDTH   = 32,
  parameter int FIR_LATENCY  = 3,
  parameter int NUM_TAPS     = 100
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               stop,
  input  logic [NUM_CHANNELS-1:0]            ch_valid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data,
`ifdef TDM_SCHED_CHMASK_EN
  input  logic [NUM_CHANNELS-1:0]            ch_enable,
`endif
  output logic [NUM_CHANNELS-1:0]            ch_ready,
  output logic [DATA_WIDTH-1:0]              fir_in_data,
  output logic                               fir_in_en,
  input  logic [DATA_WIDTH-1:0]              fir_out_data,
  output logic                               out_valid,
  output logic [$clog2(NUM_CHANNELS)-1:0]    out_channel,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [NUM_CHANNELS-1:0]            underrun,
  input  logic                               clear_status,
  output logic                               busy
);

  localparam int FLUSH_ZERO = NUM_CHANNELS * NUM_TAPS;
  localparam int FLUSH_LEN  = FLUSH_ZERO + FIR_LATENCY;
  localparam int CNT_W      = $clog2(FLUSH_LEN);
  localparam slot_t LAST_SLOT = slot_t'(NUM_CHANNELS - 1);

  sched_state_e                         state_q, state_d;
  slot_t                                slot_q, slot_d;
  logic                                 stop_pend_q, stop_pend_d;
  logic [CNT_W-1:0]                     flush_cnt_q, flush_cnt_d;
  logic [NUM_CHANNELS-1:0]              full_q, full_d;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] hold_q, hold_d;
  logic [NUM_CHANNELS-1:0]              underrun_q, underrun_d;
  logic [DATA_WIDTH-1:0]                fir_in_data_q, fir_in_data_d;
  logic                                 fir_in_en_q, fir_in_en_d;
  tag_t                                 tag_q, tag_d;
  tag_t                                 tag_out;
  logic                                 out_valid_q, out_valid_d;
  slot_t                                out_channel_q, out_channel_d;
  logic [DATA_WIDTH-1:0]                out_data_q, out_data_d;
  logic [NUM_CHANNELS-1:0]              ch_en;
  logic [NUM_CHANNELS-1:0]              drain;

`ifdef TDM_SCHED_CHMASK_EN
  assign ch_en = ch_enable;
`else
  assign ch_en = '1;
`endif

  // A channel may refill on the very cycle its slot drains the holding register.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      ch_ready[c] = ch_en[c] & (~full_q[c] | (state_q == RUN && slot_q == slot_t'(c)));
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d       = state_q;
    slot_d        = slot_q;
    stop_pend_d   = stop_pend_q;
    flush_cnt_d   = flush_cnt_q;
    full_d        = full_q;
    hold_d        = hold_q;
    underrun_d    = clear_status ? '0 : underrun_q;
    fir_in_en_d   = 1'b0;
    fir_in_data_d = '0;
    tag_d         = '0;
    drain         = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          slot_d      = '0;
          stop_pend_d = 1'b0;
        end
      end
      RUN: begin
        fir_in_en_d = 1'b1;
        tag_d.slot  = slot_q;
        if (ch_en[slot_q]) begin
          if (full_q[slot_q]) begin
            fir_in_data_d = hold_q[slot_q];
            tag_d.is_real = 1'b1;
            drain[slot_q] = 1'b1;
          end else begin
            underrun_d[slot_q] = 1'b1;
          end
        end
        slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + slot_t'(1);
        // Stop takes effect only at a frame boundary so every channel sees the same count.
        if (slot_q == LAST_SLOT && (stop_pend_q || stop)) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
          stop_pend_d = 1'b0;
        end else begin
          stop_pend_d = stop_pend_q | stop;
        end
      end
      FLUSH: begin
        fir_in_en_d = (flush_cnt_q < CNT_W'(FLUSH_ZERO));
        if (flush_cnt_q == CNT_W'(FLUSH_LEN - 1)) begin
          state_d = IDLE;
          slot_d  = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    for (int c = 0; c < NUM_CHANNELS; c++) begin
      full_d[c] = (full_q[c] & ~drain[c]) | (ch_valid[c] & ch_ready[c]);
      if (ch_valid[c] && ch_ready[c]) begin
        hold_d[c] = ch_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    out_valid_d   = tag_out.is_real;
    out_channel_d = tag_out.slot;
    out_data_d    = fir_out_data;
  end

  tdm_tag_pipe #(
    .DEPTH (FIR_LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_q),
    .tag_out (tag_out)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      stop_pend_q   <= 1'b0;
      flush_cnt_q   <= '0;
      full_q        <= '0;
      underrun_q    <= '0;
      fir_in_data_q <= '0;
      fir_in_en_q   <= 1'b0;
      tag_q         <= '0;
      out_valid_q   <= 1'b0;
      out_channel_q <= '0;
      out_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      stop_pend_q   <= stop_pend_d;
      flush_cnt_q   <= flush_cnt_d;
      full_q        <= full_d;
      underrun_q    <= underrun_d;
      fir_in_data_q <= fir_in_data_d;
      fir_in_en_q   <= fir_in_en_d;
      tag_q         <= tag_d;
      out_valid_q   <= out_valid_d;
      out_channel_q <= out_channel_d;
      out_data_q    <= out_data_d;
    end
  end

  // NOTE: holding data is not reset; the full flags alone decide whether it is meaningful.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign fir_in_data = fir_in_data_q;
  assign fir_in_en   = fir_in_en_q;
  assign out_valid   = out_valid_q;
  assign out_channel = out_channel_q;
  assign out_data    = out_data_q;
  assign underrun    = underrun_q;
  assign busy        = (state_q != IDLE);

endmodule
